rotating_xbar_pipe: RTL and testbench
=====================================

Name: rotating_xbar_pipe

Overview:
Registered, flow-controlled successor to the combinational rotating crossbar. It rotates a vector of NUM_DATA lanes by a select amount, in either direction, and carries a per-lane enable mask alongside the data. The select comes from an external value (manual mode) or from an internal round-robin pointer that advances on every accepted transfer (auto mode). The block sits between lane-parallel producers and consumers that need a valid/ready pipeline stage and fair lane rotation.

Parameters:
NUM_DATA, 4, number of lanes (>=2; need not be a power of 2)
DATA_WIDTH, 8, bits per lane
CNT_WIDTH, 16, width of the output-transfer counter
SEL_WIDTH, $clog2(NUM_DATA), select/pointer width (derived, not overridable)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
mode_auto_i  in  1  0: select = start_select_i; 1: select = internal pointer
dir_i  in  1  0: rotate toward lower lane index; 1: toward higher lane index
load_ptr_i  in  1  load pointer from start_select_i (auto mode)
start_select_i  in  SEL_WIDTH  manual select / pointer load value
data_vector_i  in  NUM_DATA*DATA_WIDTH  input lanes, lane j = bits [j*DATA_WIDTH +: DATA_WIDTH]
lane_en_i  in  NUM_DATA  per-lane enable mask
valid_i  in  1  input valid
ready_o  out  1  input ready
data_vector_o  out  NUM_DATA*DATA_WIDTH  rotated lanes (registered)
lane_en_o  out  NUM_DATA  rotated mask (registered)
valid_o  out  1  output valid
ready_i  in  1  output ready
cur_select_o  out  SEL_WIDTH  current pointer value
xfer_count_o  out  CNT_WIDTH  count of completed output handshakes

Behaviour:
- Reset (rst_i=1 at a rising edge): valid_o=0, data_vector_o=0, lane_en_o=0, pointer=0, xfer_count_o=0. Reset overrides every other event in that cycle; an in-flight output word is discarded.
- ready_o = !valid_o || ready_i (combinational). ready_o is 0 while rst_i=1.
- Accept = valid_i && ready_o. On accept, the rotated data and mask are registered and valid_o=1 on the next cycle (latency 1).
- If there is no accept and ready_i=1, valid_o goes to 0. If valid_o=1 and ready_i=0, the output holds stable (data, mask, valid).
- Effective select s, reduced mod NUM_DATA:
  - Manual mode: s = start_select_i.
  - Auto mode: s = start_select_i if load_ptr_i=1, otherwise s = pointer.
- Values >= NUM_DATA (non-power-of-2 case) are reduced mod NUM_DATA before use.
- Rotation:
  - dir_i=0: out[j] = in[(j+s) mod NUM_DATA].
  - dir_i=1: out[j] = in[(j-s+NUM_DATA) mod NUM_DATA].
  - The mask bits use the same mapping as the data lanes.
- Pointer update, auto mode:
  - Next pointer = (s+1) mod NUM_DATA on accept.
  - Next pointer = s if load_ptr_i=1 without accept.
  - Otherwise the pointer is unchanged.
- Pointer update, manual mode: the pointer is unchanged; load_ptr_i still loads it (reduced mod NUM_DATA).
- cur_select_o = pointer register.
- xfer_count_o increments by 1 when valid_o && ready_i, wrapping 2^CNT_WIDTH-1 -> 0.
- Simultaneous output handshake and new accept: full throughput, one word per cycle with no bubble.
- mode_auto_i, dir_i and start_select_i are sampled only at accept; changing them while stalled does not alter the held output.

Test Plan:
1. Manual rotation: NUM_DATA=4, DATA_WIDTH=8, in lanes[0..3]=0x10,0x21,0x32,0x43, mask=4'b0011, s=1, dir=0, ready_i=1 -> next cycle out=0x21,0x32,0x43,0x10, lane_en_o=4'b1001, valid_o=1, xfer_count_o=1 one cycle later.
2. Reverse direction: same inputs, dir=1, s=1 -> out=0x43,0x10,0x21,0x32, lane_en_o=4'b0110; s=0 in either direction -> out equals in.
3. Auto round-robin: mode_auto_i=1, load_ptr_i=1 with start_select_i=2 on the first of 5 back-to-back accepts -> selects used are 2,3,0,1,2, final cur_select_o=3, 5 valid_o cycles with no gaps.
4. Backpressure: valid_o=1 and ready_i=0 for 3 cycles with valid_i=1 and new data -> ready_o=0, output and xfer_count_o frozen; ready_i=1 -> held word completes and the new word appears the next cycle; the pointer advances only once per accepted word.
5. Reset mid-operation: rst_i=1 while valid_o=1 and pointer=3 -> next cycle valid_o=0, data=0, cur_select_o=0, xfer_count_o=0; ready_o=0 during reset.
6. Non-power-of-2 and wrap cases:
   - NUM_DATA=3, start_select_i=3 -> treated as 0.
   - NUM_DATA=3, auto pointer at 2 -> next pointer 0.
   - CNT_WIDTH=4 -> 16 handshakes wrap xfer_count_o to 0.

Source files
------------

// File: rtl/rotating_xbar_pipe.sv
// rotating_xbar_pipe: one-stage valid/ready register in front of a lane
// rotator. The rotation amount comes from the manual select input or from an
// internal round-robin pointer that moves on every accepted word.
module rotating_xbar_pipe #(
    parameter  int NUM_DATA   = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int SEL_WIDTH  = $clog2(NUM_DATA)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           mode_auto_i,
    input  logic                           dir_i,
    input  logic                           load_ptr_i,
    input  logic [SEL_WIDTH-1:0]           start_select_i,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] data_vector_i,
    input  logic [NUM_DATA-1:0]            lane_en_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic [NUM_DATA*DATA_WIDTH-1:0] data_vector_o,
    output logic [NUM_DATA-1:0]            lane_en_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [SEL_WIDTH-1:0]           cur_select_o,
    output logic [CNT_WIDTH-1:0]           xfer_count_o
);

    // NUM_DATA itself may not fit in SEL_WIDTH bits (power-of-2 case).
    localparam logic [SEL_WIDTH:0]   NUM_EXT  = (SEL_WIDTH+1)'(NUM_DATA);
    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_DATA - 1);

    logic                           valid_q;
    logic [NUM_DATA*DATA_WIDTH-1:0] data_q;
    logic [NUM_DATA-1:0]            lane_en_q;
    logic [SEL_WIDTH-1:0]           ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]           cnt_q;

    logic [SEL_WIDTH-1:0]           start_mod;
    logic [SEL_WIDTH-1:0]           sel_eff;
    logic [SEL_WIDTH-1:0]           sel_inc;
    logic                           accept;
    logic [NUM_DATA*DATA_WIDTH-1:0] data_rot;
    logic [NUM_DATA-1:0]            mask_rot;

    // The stage can take a word when empty or when its word leaves this cycle.
    assign ready_o = !rst_i && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;

    // Reduce the external select mod NUM_DATA; it is always < 2*NUM_DATA,
    // so one conditional subtract is enough.
    always_comb begin
        if ({1'b0, start_select_i} >= NUM_EXT) begin
            start_mod = SEL_WIDTH'({1'b0, start_select_i} - NUM_EXT);
        end else begin
            start_mod = start_select_i;
        end
    end

    assign sel_eff = (mode_auto_i && !load_ptr_i) ? ptr_q : start_mod;
    assign sel_inc = (sel_eff == LAST_SEL) ? '0 : sel_eff + 1'b1;

    // Rotate data lanes and mask bits with the same source-lane mapping.
    always_comb begin
        int src;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        src      = 0;
        data_rot = '0;
        mask_rot = '0;
        for (int j = 0; j < NUM_DATA; j++) begin
            if (dir_i) begin
                src = j - int'(sel_eff);
                if (src < 0) src = src + NUM_DATA;
            end else begin
                src = j + int'(sel_eff);
                if (src >= NUM_DATA) src = src - NUM_DATA;
            end
            data_rot[j*DATA_WIDTH +: DATA_WIDTH] = data_vector_i[src*DATA_WIDTH +: DATA_WIDTH];
            mask_rot[j]                          = lane_en_i[src];
        end
    end

    // Pointer: advance past the used select on an auto-mode accept, else load on request.
    always_comb begin
        ptr_d = ptr_q;
        if (mode_auto_i && accept) begin
            ptr_d = sel_inc;
        end else if (load_ptr_i) begin
            ptr_d = start_mod;
        end
    end

    // Output register, pointer and handshake counter; reset wins over everything.
    always_ff @(posedge clk_i) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples values from before this edge.
        if (rst_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            lane_en_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (valid_q && ready_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept) begin
                valid_q   <= 1'b1;
                data_q    <= data_rot;
                lane_en_q <= mask_rot;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o       = valid_q;
    assign data_vector_o = data_q;
    assign lane_en_o     = lane_en_q;
    assign cur_select_o  = ptr_q;
    assign xfer_count_o  = cnt_q;

endmodule

// File: tb/tb_rotating_xbar_pipe.sv
// Bench for rotating_xbar_pipe: a 4-lane and a 3-lane instance (both with a
// 4-bit transfer counter) share control inputs. Expected words are queued at
// accept and compared while the DUT presents them.
module tb_rotating_xbar_pipe;

    localparam int CW = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
    } word_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic        dir;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp_d;
        logic [3:0]  exp_m;
    } vec_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i, mode_auto_i, dir_i, load_ptr_i, valid_i, ready_i;
    logic [1:0]  start_select_i;
    logic [31:0] data_i;
    logic [3:0]  mask_i;

    logic          ready4, valid4, ready3, valid3;
    logic [31:0]   data4;
    logic [23:0]   data3;
    logic [3:0]    en4;
    logic [2:0]    en3;
    logic [1:0]    cur4, cur3;
    logic [CW-1:0] cnt4, cnt3;

    rotating_xbar_pipe #(.NUM_DATA(4), .DATA_WIDTH(8), .CNT_WIDTH(CW)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .mode_auto_i(mode_auto_i), .dir_i(dir_i),
        .load_ptr_i(load_ptr_i), .start_select_i(start_select_i),
        .data_vector_i(data_i), .lane_en_i(mask_i), .valid_i(valid_i),
        .ready_o(ready4), .data_vector_o(data4), .lane_en_o(en4), .valid_o(valid4),
        .ready_i(ready_i), .cur_select_o(cur4), .xfer_count_o(cnt4)
    );

    rotating_xbar_pipe #(.NUM_DATA(3), .DATA_WIDTH(8), .CNT_WIDTH(CW)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .mode_auto_i(mode_auto_i), .dir_i(dir_i),
        .load_ptr_i(load_ptr_i), .start_select_i(start_select_i),
        .data_vector_i(data_i[23:0]), .lane_en_i(mask_i[2:0]), .valid_i(valid_i),
        .ready_o(ready3), .data_vector_o(data3), .lane_en_o(en3), .valid_o(valid3),
        .ready_i(ready_i), .cur_select_o(cur3), .xfer_count_o(cnt3)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    word_t q4[$];
    word_t q3[$];
    logic  m_valid = 1'b0;
    int    m_ptr4  = 0;
    int    m_ptr3  = 0;
    int    m_cnt   = 0;
    bit    use_tbl = 1'b0;
    word_t tbl_exp;
    vec_t  tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rotation: out[j] = in[(j+s) mod n] or in[(j-s+n) mod n].
    function automatic word_t rot(input logic [31:0] d, input logic [3:0] m,
                                  input int n, input int s, input logic dir);
        word_t w;
        int    src;
        w = '0;
        for (int j = 0; j < n; j++) begin
            src = dir ? (j - s + n) % n : (j + s) % n;
            w.d[j*8 +: 8] = d[src*8 +: 8];
            w.m[j]        = m[src];
        end
        return w;
    endfunction

    // Compare outputs at the falling edge, then predict the next rising edge.
    task automatic tick();
        logic exp_rdy;
        int   s4, s3, st;
        @(negedge clk_i);
        exp_rdy = !rst_i && (!m_valid || ready_i);
        check("ready_o4", 64'(ready4), 64'(exp_rdy));
        check("ready_o3", 64'(ready3), 64'(exp_rdy));
        check("valid_o4", 64'(valid4), 64'(m_valid));
        check("valid_o3", 64'(valid3), 64'(m_valid));
        check("cur_select4", 64'(cur4), 64'(m_ptr4));
        check("cur_select3", 64'(cur3), 64'(m_ptr3));
        check("xfer_count4", 64'(cnt4), 64'(m_cnt));
        check("xfer_count3", 64'(cnt3), 64'(m_cnt));
        if (m_valid) begin
            if (q4.size() == 0 || q3.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: valid_o=1 with no expected word queued");
            end else begin
                check("data_o4", 64'(data4), 64'(q4[0].d));
                check("lane_en_o4", 64'(en4), 64'(q4[0].m));
                check("data_o3", 64'(data3), 64'(q3[0].d[23:0]));
                check("lane_en_o3", 64'(en3), 64'(q3[0].m[2:0]));
            end
        end
        st = int'(start_select_i);
        if (rst_i) begin
            m_valid = 1'b0;
            m_ptr4  = 0;
            m_ptr3  = 0;
            m_cnt   = 0;
            q4.delete();
            q3.delete();
        end else begin
            if (m_valid && ready_i) begin
                m_cnt = (m_cnt + 1) % 16;
                if (q4.size() > 0) void'(q4.pop_front());
                if (q3.size() > 0) void'(q3.pop_front());
            end
            s4 = (mode_auto_i && !load_ptr_i) ? m_ptr4 : st % 4;
            s3 = (mode_auto_i && !load_ptr_i) ? m_ptr3 : st % 3;
            if (valid_i && exp_rdy) begin
                q4.push_back(use_tbl ? tbl_exp : rot(data_i, mask_i, 4, s4, dir_i));
                q3.push_back(rot(data_i, mask_i, 3, s3, dir_i));
                m_valid = 1'b1;
                if (mode_auto_i) begin
                    m_ptr4 = (s4 + 1) % 4;
                    m_ptr3 = (s3 + 1) % 3;
                end else if (load_ptr_i) begin
                    m_ptr4 = st % 4;
                    m_ptr3 = st % 3;
                end
            end else begin
                if (ready_i) m_valid = 1'b0;
                if (load_ptr_i) begin
                    m_ptr4 = st % 4;
                    m_ptr3 = st % 3;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // sel, dir, data, mask, expected 4-lane data, expected 4-lane mask
        tbl[0] = '{2'd1, 1'b0, 32'h43322110, 4'b0011, 32'h10433221, 4'b1001};
        tbl[1] = '{2'd1, 1'b1, 32'h43322110, 4'b0011, 32'h32211043, 4'b0110};
        tbl[2] = '{2'd0, 1'b0, 32'h43322110, 4'b0011, 32'h43322110, 4'b0011};
        tbl[3] = '{2'd0, 1'b1, 32'h43322110, 4'b0011, 32'h43322110, 4'b0011};
        tbl[4] = '{2'd2, 1'b0, 32'h43322110, 4'b0011, 32'h21104332, 4'b1100};
        tbl[5] = '{2'd3, 1'b1, 32'h43322110, 4'b0011, 32'h10433221, 4'b1001};
        tbl[6] = '{2'd3, 1'b0, 32'hDDCCBBAA, 4'b0001, 32'hCCBBAADD, 4'b0010};

        rst_i = 1'b1; mode_auto_i = 1'b0; dir_i = 1'b0; load_ptr_i = 1'b0;
        start_select_i = '0; data_i = '0; mask_i = '0; valid_i = 1'b0; ready_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset state, ready_o low while reset is held.
        valid_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0; valid_i = 1'b0;
        tick();
        check("reset_data4", 64'(data4), 64'h0);
        check("reset_en4", 64'(en4), 64'h0);

        // Manual-mode vectors, back to back at full throughput.
        ready_i = 1'b1; valid_i = 1'b1;
        foreach (tbl[i]) begin
            start_select_i = tbl[i].sel;
            dir_i          = tbl[i].dir;
            data_i         = tbl[i].data;
            mask_i         = tbl[i].mask;
            tbl_exp        = '{d: tbl[i].exp_d, m: tbl[i].exp_m};
            use_tbl        = 1'b1;
            tick();
        end
        use_tbl = 1'b0; valid_i = 1'b0;
        tick();
        tick();
        check("count_after_table", 64'(cnt4), 64'd7);

        // Auto round robin: load 2 on the first of five accepts.
        mode_auto_i = 1'b1; load_ptr_i = 1'b1; start_select_i = 2'd2; dir_i = 1'b0;
        valid_i = 1'b1; data_i = 32'h44332211; mask_i = 4'b0101;
        tick();
        load_ptr_i = 1'b0;
        repeat (4) begin
            data_i = data_i + 32'h01010101;
            tick();
        end
        valid_i = 1'b0;
        tick();
        check("rr_ptr4", 64'(cur4), 64'd3);
        check("rr_ptr3", 64'(cur3), 64'd1);

        // Backpressure: held word stays put while stalled inputs wiggle.
        valid_i = 1'b1; data_i = 32'hA1B2C3D4; mask_i = 4'b1110;
        tick();
        ready_i = 1'b0; data_i = 32'h55667788; mask_i = 4'b0111;
        repeat (3) begin
            dir_i = ~dir_i;
            start_select_i = start_select_i + 2'd1;
            tick();
        end
        check("bp_ptr4_frozen", 64'(cur4), 64'd0);
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        check("bp_ptr4", 64'(cur4), 64'd1);
        check("bp_ptr3_wrap", 64'(cur3), 64'd0);

        // Manual load of 3: 3-lane pointer reduces to 0, rotation by 3 is identity.
        mode_auto_i = 1'b0; dir_i = 1'b0; load_ptr_i = 1'b1; start_select_i = 2'd3;
        tick();
        load_ptr_i = 1'b0;
        check("load_ptr4", 64'(cur4), 64'd3);
        check("load_ptr3_mod", 64'(cur3), 64'd0);
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h0F1E2D3C; mask_i = 4'b1010;
        tick();
        valid_i = 1'b0;
        tick();
        check("sel3_identity_data", 64'(data3), 64'h1E2D3C);
        check("sel3_identity_mask", 64'(en3), 64'h2);

        // Reset with a word held and pointer at 3.
        rst_i = 1'b1; valid_i = 1'b1;
        tick();
        check("rst_valid", 64'(valid4), 64'd0);
        check("rst_data", 64'(data4), 64'h0);
        check("rst_ptr", 64'(cur4), 64'd0);
        check("rst_count", 64'(cnt4), 64'd0);
        check("rst_ready", 64'(ready4), 64'd0);
        rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        tick();

        // Sixteen handshakes wrap the 4-bit counter back to 0.
        valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            start_select_i = 2'(i);
            dir_i          = 1'($urandom_range(0, 1));
            data_i         = $urandom;
            mask_i         = 4'($urandom_range(0, 15));
            tick();
        end
        valid_i = 1'b0;
        tick();
        check("count_wrap4", 64'(cnt4), 64'd0);
        check("count_wrap3", 64'(cnt3), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
